// File: rtl/vga_scanout_if.sv
// Framebuffer read port: vga_scanout issues reads (master), the framebuffer RAM answers (slave).
interface vga_scanout_if;
  logic        rd_en;
  logic [17:0] rd_addr;
  logic [3:0]  rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout of a double-buffered 320x240x4 framebuffer with 2x2 pixel replication.
// Timing flags ride a shift register matched to the RAM latency so syncs and RGB switch together.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = 320,
  parameter int RD_LAT   = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          buffer_select,
  vga_scanout_if.master fb,
  output logic          front_buffer,
  output logic          frame_done,
  output logic          vblank,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SWAP   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
    logic vblank;
  } timing_t;

  localparam timing_t TIMING_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, vblank: 1'b0};

  logic        r_pix_en;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  timing_t     r_timing [RD_LAT+1];
  logic [RD_LAT-1:0] r_rd_vld;
  logic [3:0]  r_gray;

  timing_t     w_timing;
  logic [16:0] w_y;
  logic [16:0] w_row;
  logic [16:0] w_pix_idx;
  logic        w_tick_active;
  logic        w_swap;

  // NOTE: every field is assigned on every pass, so this stays pure combinational logic.
  always_comb begin
    w_timing.active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    w_timing.hs_n   = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
    w_timing.vs_n   = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
    w_timing.vblank = (r_v_cnt >= V_ACT);
  end

  assign w_y = 17'(r_v_cnt[9:1]);

  generate
    if (FB_W == 320) begin : g_row_320
      assign w_row = (w_y << 8) + (w_y << 6);
    end else begin : g_row_mul
      assign w_row = w_y * 17'(FB_W);
    end
  endgenerate

  assign w_pix_idx     = w_row + 17'(r_h_cnt[9:1]);
  assign w_tick_active = r_pix_en && w_timing.active;
  assign w_swap        = r_pix_en && (r_h_cnt == H_LAST) && (r_v_cnt == V_SWAP);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pix_en     <= 1'b0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      fb.rd_en     <= 1'b0;
      fb.rd_addr   <= '0;
      front_buffer <= 1'b0;
      frame_done   <= 1'b0;
      // NOTE: the delay line is a handful of flops, so it is cleared to idle timing rather than left unreset.
      for (int i = 0; i <= RD_LAT; i++) r_timing[i] <= TIMING_IDLE;
      r_rd_vld     <= '0;
      r_gray       <= '0;
      vga_hs       <= 1'b1;
      vga_vs       <= 1'b1;
      vblank       <= 1'b0;
    end else begin
      r_pix_en <= !r_pix_en;

      if (r_pix_en) begin
        if (r_h_cnt == H_LAST) begin
          r_h_cnt <= '0;
          r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
        r_timing[0] <= w_timing;
      end

      fb.rd_en <= w_tick_active;
      if (w_tick_active) fb.rd_addr <= {front_buffer, w_pix_idx};

      frame_done <= w_swap;
      if (w_swap) front_buffer <= buffer_select;

      for (int i = 1; i <= RD_LAT; i++) r_timing[i] <= r_timing[i-1];
      r_rd_vld <= (r_rd_vld << 1) | RD_LAT'(fb.rd_en);

      // Capture only on the cycle the RAM answers; hold for the replicated second clk.
      if (!r_timing[RD_LAT].active) r_gray <= '0;
      else if (r_rd_vld[RD_LAT-1])  r_gray <= fb.rd_data;

      vga_hs <= r_timing[RD_LAT].hs_n;
      vga_vs <= r_timing[RD_LAT].vs_n;
      vblank <= r_timing[RD_LAT].vblank;
    end
  end

  assign vga_r = r_gray;
  assign vga_g = r_gray;
  assign vga_b = r_gray;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout: full horizontal timing, shortened vertical timing,
// pixel-level output model driven by the cycle count since reset release.
module tb_vga_scanout;
  localparam int H_ACT  = 640;
  localparam int H_TOT  = 800;
  localparam int V_ACT  = 6;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 1;
  localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME  = H_TOT * V_TOT;
  localparam int SWAP_P = (V_ACT - 1) * H_TOT + H_TOT - 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       buffer_select = 1'b1;
  logic       front_buffer, frame_done, vblank, vga_hs, vga_vs;
  logic [3:0] vga_r, vga_g, vga_b;

  vga_scanout_if fb ();

  vga_scanout #(.V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .buffer_select (buffer_select),
    .fb            (fb),
    .front_buffer  (front_buffer),
    .frame_done    (frame_done),
    .vblank        (vblank),
    .vga_r         (vga_r),
    .vga_g         (vga_g),
    .vga_b         (vga_b),
    .vga_hs        (vga_hs),
    .vga_vs        (vga_vs)
  );

  always #10 clk = ~clk;

  // Framebuffer model: two-clk latency, returns the low address nibble, 4'hF when idle.
  logic [3:0] ram_q1 = 4'hF;
  logic [3:0] ram_q2 = 4'hF;
  always @(posedge clk) begin
    ram_q1 <= fb.rd_en ? fb.rd_addr[3:0] : 4'hF;
    ram_q2 <= ram_q1;
  end
  assign fb.rd_data = ram_q2;

  int cyc = 0;
  int abs_cyc = 0;
  bit started = 1'b0;
  always @(posedge clk) begin
    abs_cyc <= abs_cyc + 1;
    if (!reset_n) begin
      cyc     <= 0;
      started <= 1'b1;
    end else begin
      cyc <= cyc + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
      if (n_fail >= 20) finish_run();
    end
  endtask

  function automatic int pix_h(int p);
    return (p % FRAME) % H_TOT;
  endfunction

  function automatic int pix_v(int p);
    return (p % FRAME) / H_TOT;
  endfunction

  function automatic bit pix_active(int p);
    return (pix_h(p) < H_ACT) && (pix_v(p) < V_ACT);
  endfunction

  function automatic int pix_idx(int p);
    return (pix_v(p) / 2) * 320 + pix_h(p) / 2;
  endfunction

  // Pixel p is ticked on cycle 2p+1, its read is visible on 2p+2, its video on 2p+5 and 2p+6.
  bit          exp_front  = 1'b0;
  bit          front_prev = 1'b0;
  bit          sel_prev   = 1'b0;
  logic [17:0] exp_addr   = '0;

  always @(negedge clk) begin : compare
    int c, p, h, v;
    bit e_rd_en, e_fd, e_hs, e_vs, e_vb;
    logic [3:0] e_rgb;
    if (started) begin
      c = cyc;
      e_rd_en = 1'b0;
      e_fd    = 1'b0;
      if (c == 0) begin
        exp_front = 1'b0;
        exp_addr  = '0;
      end else if (c >= 2 && c % 2 == 0) begin
        p = (c - 2) / 2;
        if (pix_active(p)) begin
          e_rd_en  = 1'b1;
          exp_addr = {front_prev, 17'(pix_idx(p))};
        end
        if (p % FRAME == SWAP_P) begin
          e_fd      = 1'b1;
          exp_front = sel_prev;
        end
      end

      if (c < 5) begin
        e_hs = 1'b1; e_vs = 1'b1; e_vb = 1'b0; e_rgb = 4'h0;
      end else begin
        p = (c - 5) / 2;
        h = pix_h(p);
        v = pix_v(p);
        e_hs  = !(h >= 656 && h < 752);
        e_vs  = !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYNC);
        e_vb  = (v >= V_ACT);
        e_rgb = pix_active(p) ? 4'(pix_idx(p) % 16) : 4'h0;
      end

      check("rd_en", fb.rd_en, e_rd_en);
      check("rd_addr", fb.rd_addr, exp_addr);
      check("front_buffer", front_buffer, exp_front);
      check("frame_done", frame_done, e_fd);
      check("vga_hs", vga_hs, e_hs);
      check("vga_vs", vga_vs, e_vs);
      check("vblank", vblank, e_vb);
      check("rgb", {vga_r, vga_g, vga_b}, {e_rgb, e_rgb, e_rgb});

      // Hand-computed anchors for the model.
      case (c)
        0:     check("rst_front_lit", front_buffer, 0);
        1:     check("rd_en_c1_lit", fb.rd_en, 0);
        2:     begin check("rd_en_c2_lit", fb.rd_en, 1); check("addr_0_0_lit", fb.rd_addr, 0); end
        4:     check("addr_1_0_lit", fb.rd_addr, 0);
        6:     check("addr_2_0_lit", fb.rd_addr, 1);
        12:    check("rgb_px3_lit", vga_r, 4'd1);
        13:    check("rgb_px4_lit", vga_r, 4'd2);
        1316:  check("hs_before_lit", vga_hs, 1);
        1317:  check("hs_px656_lit", vga_hs, 0);
        3202:  check("addr_0_2_lit", fb.rd_addr, 320);
        9280:  check("addr_639_5_lit", fb.rd_addr, 959);
        9600:  check("frame_done_lit", frame_done, 1);
        16002: check("addr_fb1_lit", fb.rd_addr, 18'd131072);
        default: ;
      endcase

      front_prev = exp_front;
      sel_prev   = buffer_select;
    end
  end

  // Period and width measurements of the video syncs and vblank.
  bit hs_d = 1'b1, vs_d = 1'b1, vb_d = 1'b0;
  int hs_fall = -1, vs_fall = -1, vb_rise = -1;
  always @(negedge clk) begin
    if (started) begin
      if (cyc == 0) begin
        hs_fall = -1; vs_fall = -1; vb_rise = -1;
      end else begin
        if (hs_d && !vga_hs) begin
          if (hs_fall >= 0) check("hs_period", abs_cyc - hs_fall, 1600);
          hs_fall = abs_cyc;
        end
        if (!hs_d && vga_hs && hs_fall >= 0) check("hs_low", abs_cyc - hs_fall, 192);
        if (vs_d && !vga_vs) begin
          if (vs_fall >= 0) check("vs_period", abs_cyc - vs_fall, FRAME * 2);
          vs_fall = abs_cyc;
        end
        if (!vs_d && vga_vs && vs_fall >= 0) check("vs_low", abs_cyc - vs_fall, 3200);
        if (!vb_d && vblank) vb_rise = abs_cyc;
        if (vb_d && !vblank && vb_rise >= 0) check("vblank_high", abs_cyc - vb_rise, 6400);
      end
      hs_d = vga_hs;
      vs_d = vga_vs;
      vb_d = vblank;
    end
  end

  task automatic wait_cyc(input int n);
    int guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (cyc != n && guard < 60000);
    if (cyc != n) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_cyc: reached %0d, expected %0d", cyc, n);
      finish_run();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    buffer_select = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b1;
    buffer_select = 1'b0;

    wait_cyc(3201);            // frame 0, v=2: request buffer 1
    buffer_select = 1'b1;
    wait_cyc(20801);           // frame 1, v=3: mid-frame toggles must be ignored
    buffer_select = 1'b0;
    wait_cyc(22401);           // frame 1, v=4
    buffer_select = 1'b1;

    wait_cyc(37401);           // frame 2, h=300 v=3, front_buffer=1
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    wait_cyc(9599);            // reset lands on the swap tick edge
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    wait_cyc(17000);
    finish_run();
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read-side counterpart to the rasterizer's framebuffer write port.
- Generates 640x480@60 VGA timing from a 50 MHz clock.
- Reads the front buffer of the double-buffered 320x240x4-bit framebuffer with 2x pixel/line replication, and drives 12-bit RGB plus syncs.
- Latches the GPU-side buffer_select only at the start of vertical blanking, so swaps never tear.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- FB_W, 320, framebuffer width in pixels
- RD_LAT, 2, framebuffer read latency in clk cycles, rd_en to rd_data valid

Ports:
- clk  in  1  50 MHz system clock
- reset_n  in  1  synchronous reset, active-low
- buffer_select  in  1  back/front select from the GPU controller; sampled only at vblank entry
- rd_en  out  1  framebuffer read strobe
- rd_addr  out  18  {front_buffer, 17-bit pixel index}
- rd_data  in  4  framebuffer pixel, valid RD_LAT clks after rd_en
- front_buffer  out  1  buffer currently scanned out
- frame_done  out  1  one-clk pulse at vblank entry
- vblank  out  1  high while v_cnt >= V_ACTIVE, aligned to the video outputs
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  hsync, active-low
- vga_vs  out  1  vsync, active-low

Behaviour:
- One clock domain. All state updates on posedge clk; reset_n is sampled only at posedge clk.
- Reset (reset_n=0), next edge:
  - pix_en phase=0, h_cnt=0, v_cnt=0, all delay pipelines cleared.
  - front_buffer=0, frame_done=0, rd_en=0, rd_addr=0.
  - vga_r/g/b=0, vga_hs=1, vga_vs=1, vblank=0.
- Reset asserted mid-frame takes effect on the next edge regardless of counter position. The first tick after release is at h=0, v=0.
- Pixel tick:
  - pix_en toggles every clk and is 1 on the first clk after reset release.
  - Counters advance only when pix_en=1, giving a 25 MHz pixel rate.
- Counters:
  - h_cnt runs 0..799 (total = H_ACTIVE+H_FP+H_SYNC+H_BP), then wraps to 0 and increments v_cnt.
  - v_cnt runs 0..524, then wraps to 0.
- Raw timing, per counter position:
  - active = (h_cnt<640) && (v_cnt<480).
  - hs_raw low for 656<=h_cnt<752.
  - vs_raw low for 490<=v_cnt<492.
  - vblank_raw = v_cnt>=480.
- Read issue: on a tick cycle t, rd_en<=active and rd_addr<={front_buffer, (v_cnt>>1)*FB_W + (h_cnt>>1)}, both visible at t+1. rd_en=0 on non-tick cycles and while inactive. rd_addr holds its last value when rd_en=0.
- Address arithmetic: pixel index range is 0..76799 and fits in 17 bits unsigned. The multiply by FB_W is implemented as (y<<8)+(y<<6).
- Data path:
  - rd_data arrives at t+1+RD_LAT.
  - vga_r=vga_g=vga_b=rd_data (grayscale) is registered at t+2+RD_LAT when the delayed active flag is 1; otherwise 0.
  - RGB must be 0 in blanking regardless of rd_data.
- Alignment: hs_raw, vs_raw, vblank_raw and active pass through a (2+RD_LAT)-stage clk shift register, so syncs, vblank and RGB change on the same edge. Total pipeline latency is 2+RD_LAT clks (4 at default).
- Buffer swap:
  - On the tick where h_cnt=799 and v_cnt=479, front_buffer<=buffer_select and frame_done=1 for exactly one clk.
  - buffer_select changes at any other time have no effect until the next such tick.
  - The first read of the next frame (v=0, h=0) uses the new front_buffer.
- Simultaneous events: if reset_n=0 coincides with the swap tick, reset wins (front_buffer=0, no frame_done).
- No backpressure. The framebuffer read port must accept a read every second clk.

Test Plan:
- Reset: hold reset_n=0 for 10 clks with buffer_select=1 -> vga_hs=vga_vs=1, RGB=0, rd_en=0, front_buffer=0. After release, first rd_en=1 at clk 2 with rd_addr=0.
- Sync timing: run 2 frames -> hs period 1600 clks, low 192 clks. vs period 840000 clks, low 3200 clks. vblank high 72000 clks per frame.
- Address mapping: front_buffer=0 -> (h,v)=(0,0) gives 0, (1,0) gives 0, (2,0) gives 1, (0,2) gives 320, (639,479) gives 76799. With front_buffer=1, (0,0) gives 131072.
- Latency/blanking: RAM model returns rd_addr[3:0] after RD_LAT -> pixel (4,0) appears on RGB exactly 4 clks after its tick, aligned with the hs/vs delay. RGB=0 throughout h_cnt>=640 even though the model drives 4'hF.
- Buffer swap: toggle buffer_select to 1 at v=100 -> rd_addr[17] stays 0 through v=479. frame_done pulses once at (799,479). rd_addr[17]=1 from v=0 of the next frame. No further pulse until the following frame.
- Reset mid-operation: assert reset_n=0 for 1 clk at h=300, v=200, front_buffer=1 -> next edge counters=0, front_buffer=0, RGB=0, pipelines cleared. Timing restarts identically to the post-reset case.
